// File: rtl/axi_sram_slave_if.sv
// AXI4 slave-side bus bundle (AW/W/B/AR/R) between the interconnect and axi_sram_slave.
interface axi_sram_slave_if #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4
);
  logic [ID_BITS-1:0]   AWID_S;
  logic [ADDR_BITS-1:0] AWADDR_S;
  logic [LEN_BITS-1:0]  AWLEN_S;
  logic [2:0]           AWSIZE_S;
  logic [1:0]           AWBURST_S;
  logic                 AWVALID_S;
  logic                 AWREADY_S;

  logic [DATA_BITS-1:0] WDATA_S;
  logic [3:0]           WSTRB_S;
  logic                 WLAST_S;
  logic                 WVALID_S;
  logic                 WREADY_S;

  logic [ID_BITS-1:0]   BID_S;
  logic [1:0]           BRESP_S;
  logic                 BVALID_S;
  logic                 BREADY_S;

  logic [ID_BITS-1:0]   ARID_S;
  logic [ADDR_BITS-1:0] ARADDR_S;
  logic [LEN_BITS-1:0]  ARLEN_S;
  logic [2:0]           ARSIZE_S;
  logic [1:0]           ARBURST_S;
  logic                 ARVALID_S;
  logic                 ARREADY_S;

  logic [ID_BITS-1:0]   RID_S;
  logic [DATA_BITS-1:0] RDATA_S;
  logic [1:0]           RRESP_S;
  logic                 RLAST_S;
  logic                 RVALID_S;
  logic                 RREADY_S;

  modport master (
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S
  );

  modport slave (
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder for one synchronous single-port SRAM; one transaction in flight at a time.
// Optional: define AXI_SRAM_SLAVE_WRAP_BURST_EN for WRAP burst support (otherwise WRAP acts as INCR).
module axi_sram_slave #(
  parameter int ID_BITS       = 8,
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int LEN_BITS      = 4,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_sram_slave_if.slave          axi,
  output logic                     sram_cs,
  output logic                     sram_oe,
  output logic [3:0]               sram_web,
  output logic [MEM_ADDR_BITS-1:0] sram_a,
  output logic [31:0]              sram_di,
  input  logic [31:0]              sram_do
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_BITS-1:0]   id_q;
  logic [ADDR_BITS-1:0] addr_q, addr_inc, addr_nxt;
  logic [LEN_BITS-1:0]  len_q, cnt_q;
  logic [1:0]           burst_q;
  logic [31:0]          rdata_q;
  logic                 err_q, rd_first_q;
  logic                 aw_hs, ar_hs, w_beat, r_hs, last_beat;

`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
  logic [ADDR_BITS-1:0] wrap_mask;

  function automatic logic wrap_len_ok(input logic [LEN_BITS-1:0] len);
    return (len == LEN_BITS'(1)) || (len == LEN_BITS'(3)) ||
           (len == LEN_BITS'(7)) || (len == LEN_BITS'(15));
  endfunction
`endif

  always_comb begin
    last_beat = (cnt_q == len_q);
    aw_hs     = (state_q == IDLE) && axi.AWVALID_S;
    ar_hs     = (state_q == IDLE) && axi.ARVALID_S && !axi.AWVALID_S;
    w_beat    = (state_q == WR_DATA) && axi.WVALID_S;
    r_hs      = (state_q == RD_DATA) && axi.RREADY_S;
  end

  always_comb begin
    addr_inc = addr_q + ADDR_BITS'(4);
    addr_nxt = addr_inc;
`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
    wrap_mask = ((ADDR_BITS'(len_q) + ADDR_BITS'(1)) << 2) - ADDR_BITS'(1);
`endif
    if (burst_q == 2'b00) begin
      addr_nxt = addr_q;
    end
`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
    // Low bits follow the increment, upper bits stay on the aligned wrap base.
    else if ((burst_q == 2'b10) && wrap_len_ok(len_q)) begin
      addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = WR_DATA;
               else if (ar_hs) state_d = RD_ADDR;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = last_beat ? IDLE : RD_ADDR;
      WR_DATA: if (w_beat && last_beat) state_d = WR_RESP;
      WR_RESP: if (axi.BREADY_S) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_first_q <= (state_q == RD_ADDR);
      if (rd_first_q) rdata_q <= sram_do;
      if (aw_hs) begin
        id_q    <= axi.AWID_S;
        addr_q  <= axi.AWADDR_S;
        len_q   <= axi.AWLEN_S;
        burst_q <= axi.AWBURST_S;
        cnt_q   <= '0;
`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
        err_q   <= (axi.AWBURST_S == 2'b10) && !wrap_len_ok(axi.AWLEN_S);
`else
        err_q   <= 1'b0;
`endif
      end else if (ar_hs) begin
        id_q    <= axi.ARID_S;
        addr_q  <= axi.ARADDR_S;
        len_q   <= axi.ARLEN_S;
        burst_q <= axi.ARBURST_S;
        cnt_q   <= '0;
`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
        err_q   <= (axi.ARBURST_S == 2'b10) && !wrap_len_ok(axi.ARLEN_S);
`else
        err_q   <= 1'b0;
`endif
      end
      if (w_beat || (r_hs && !last_beat)) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + LEN_BITS'(1);
      end
      if (w_beat && (axi.WLAST_S != last_beat)) err_q <= 1'b1;
    end
  end

  always_comb begin
    axi.AWREADY_S = 1'b0;
    axi.ARREADY_S = 1'b0;
    axi.WREADY_S  = 1'b0;
    axi.BID_S     = '0;
    axi.BRESP_S   = 2'b00;
    axi.BVALID_S  = 1'b0;
    axi.RID_S     = '0;
    axi.RDATA_S   = '0;
    axi.RRESP_S   = 2'b00;
    axi.RLAST_S   = 1'b0;
    axi.RVALID_S  = 1'b0;
    sram_cs       = 1'b0;
    sram_oe       = 1'b0;
    sram_web      = '1;
    sram_a        = '0;
    sram_di       = '0;
    case (state_q)
      IDLE: begin
        // Readies stay low while reset is held so every AXI output reads 0.
        if (!rst) begin
          axi.AWREADY_S = 1'b1;
          axi.ARREADY_S = !axi.AWVALID_S;
        end
      end
      RD_ADDR: begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_a  = addr_q[MEM_ADDR_BITS+1:2];
      end
      RD_DATA: begin
        axi.RVALID_S = 1'b1;
        axi.RID_S    = id_q;
        axi.RRESP_S  = err_q ? 2'b10 : 2'b00;
        axi.RLAST_S  = last_beat;
        // SRAM output is only valid in the first cycle; afterwards the latched copy is shown.
        axi.RDATA_S  = rd_first_q ? sram_do : rdata_q;
      end
      WR_DATA: begin
        axi.WREADY_S = 1'b1;
        if (axi.WVALID_S) begin
          sram_cs  = 1'b1;
          sram_web = ~axi.WSTRB_S;
          sram_a   = addr_q[MEM_ADDR_BITS+1:2];
          sram_di  = axi.WDATA_S;
        end
      end
      WR_RESP: begin
        axi.BVALID_S = 1'b1;
        axi.BID_S    = id_q;
        axi.BRESP_S  = err_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;

  localparam int TMO = 50;

  logic        clk;
  logic        rst;
  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di, sram_do;

  axi_sram_slave_if #(.ID_BITS(8), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)) bus ();

  axi_sram_slave #(
    .ID_BITS(8), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4), .MEM_ADDR_BITS(14)
  ) dut (
    .clk(clk), .rst(rst), .axi(bus.slave),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: one-cycle read latency, byte writes, garbage on the output when not reading.
  logic [31:0] mem [0:16383];
  logic [13:0] last_wr_a;
  logic        tb_we;
  logic [13:0] tb_a;
  logic [31:0] tb_d;

  always @(posedge clk) begin
    if (sram_cs && sram_oe) sram_do <= mem[sram_a];
    else                    sram_do <= $urandom;
    if (tb_we) mem[tb_a] <= tb_d;
    else if (sram_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_web[b]) begin
          mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
          last_wr_a <= sram_a;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] wdata_v [16];
  logic [3:0]  wstrb_v [16];
  logic [31:0] exp_v   [16];
  int          stall_v [16];
  logic        ar_rdy_at_b;
  logic [7:0]  bid;
  logic [1:0]  bresp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [13:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 16; i++) stall_v[i] = 0;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int n;
    bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = len;
    bus.AWSIZE_S = 3'd2; bus.AWBURST_S = burst; bus.AWVALID_S = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.AWREADY_S && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("aw_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic w_send(input int len, input int last_at);
    int n;
    for (int i = 0; i <= len; i++) begin
      bus.WDATA_S = wdata_v[i]; bus.WSTRB_S = wstrb_v[i];
      bus.WLAST_S = (i == last_at); bus.WVALID_S = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.WREADY_S && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) check("w_timeout", 64'(n), 64'(0));
      @(posedge clk); #1;
    end
    bus.WVALID_S = 1'b0;
    bus.WLAST_S  = 1'b0;
  endtask

  task automatic b_recv(output logic [7:0] id, output logic [1:0] resp);
    int n;
    bus.BREADY_S = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.BVALID_S && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("b_timeout", 64'(n), 64'(0));
    id = bus.BID_S; resp = bus.BRESP_S; ar_rdy_at_b = bus.ARREADY_S;
    @(posedge clk); #1;
    bus.BREADY_S = 1'b0;
  endtask

  task automatic ar_wait(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.ARREADY_S && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check("ar_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    bus.ARVALID_S = 1'b0;
  endtask

  task automatic ar_set(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst);
    bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len;
    bus.ARSIZE_S = 3'd2; bus.ARBURST_S = burst; bus.ARVALID_S = 1'b1;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int n;
    ar_set(id, addr, len, burst);
    ar_wait(n);
  endtask

  task automatic r_recv(input int len, input int nbeats, input logic [7:0] exp_id,
                        input logic [1:0] exp_resp);
    int n;
    logic [31:0] held;
    for (int i = 0; i < nbeats; i++) begin
      bus.RREADY_S = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.RVALID_S && n < TMO) begin @(negedge clk); n++; end
      check($sformatf("r_latency_b%0d", i), 64'(n), 64'(1));
      held = bus.RDATA_S;
      for (int s = 0; s < stall_v[i]; s++) begin
        @(negedge clk);
        check($sformatf("rdata_hold_b%0d", i), 64'(bus.RDATA_S), 64'(held));
        check($sformatf("rvalid_hold_b%0d", i), 64'(bus.RVALID_S), 64'(1));
      end
      check($sformatf("rdata_b%0d", i), 64'(bus.RDATA_S), 64'(exp_v[i]));
      check($sformatf("rlast_b%0d", i), 64'(bus.RLAST_S), 64'(i == len));
      check($sformatf("rresp_b%0d", i), 64'(bus.RRESP_S), 64'(exp_resp));
      check($sformatf("rid_b%0d", i), 64'(bus.RID_S), 64'(exp_id));
      bus.RREADY_S = 1'b1;
      @(posedge clk); #1;
      bus.RREADY_S = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; tb_we = 1'b0; tb_a = '0; tb_d = '0;
    bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = '0;
    bus.AWBURST_S = '0; bus.AWVALID_S = 1'b0;
    bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b0;
    bus.BREADY_S = 1'b0;
    bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0; bus.ARSIZE_S = '0;
    bus.ARBURST_S = '0; bus.ARVALID_S = 1'b0; bus.RREADY_S = 1'b0;
    clear_stalls();

    poke(14'd4, 32'h1122_3344);
    for (int i = 0; i < 8; i++) poke(14'(32'h40 + i), 32'hC0DE_0040 + 32'(i));
    poke(14'hC1, 32'h5555_5555);
    poke(14'h101, 32'h0000_0000);

    // Reset values
    @(negedge clk);
    check("rst_awready", 64'(bus.AWREADY_S), 64'(0));
    check("rst_arready", 64'(bus.ARREADY_S), 64'(0));
    check("rst_wready", 64'(bus.WREADY_S), 64'(0));
    check("rst_bvalid", 64'(bus.BVALID_S), 64'(0));
    check("rst_rvalid", 64'(bus.RVALID_S), 64'(0));
    check("rst_rdata", 64'(bus.RDATA_S), 64'(0));
    check("rst_bresp", 64'(bus.BRESP_S), 64'(0));
    check("rst_sram_cs", 64'(sram_cs), 64'(0));
    check("rst_sram_oe", 64'(sram_oe), 64'(0));
    check("rst_sram_web", 64'(sram_web), 64'(4'hF));
    check("rst_sram_a", 64'(sram_a), 64'(0));
    check("rst_sram_di", 64'(sram_di), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single partial-strobe write
    aw_send(8'h5A, 32'h0000_0010, 4'd0, 2'b01);
    wdata_v[0] = 32'hAABB_CCDD; wstrb_v[0] = 4'b0011;
    w_send(0, 0);
    b_recv(bid, bresp);
    check("t1_bid", 64'(bid), 64'(8'h5A));
    check("t1_bresp", 64'(bresp), 64'(2'b00));
    check("t1_mem", 64'(mem[4]), 64'(32'h1122_CCDD));
    check("t1_sram_a", 64'(last_wr_a), 64'(4));

    // 4-beat INCR read with RREADY stalled on beat 2
    ar_send(8'h21, 32'h0000_0100, 4'd3, 2'b01);
    clear_stalls(); stall_v[1] = 3;
    for (int i = 0; i < 4; i++) exp_v[i] = 32'hC0DE_0040 + 32'(i);
    r_recv(3, 4, 8'h21, 2'b00);
    clear_stalls();

    // AW and AR together: write first, read after the B handshake
    bus.AWID_S = 8'h33; bus.AWADDR_S = 32'h20; bus.AWLEN_S = 4'd0;
    bus.AWSIZE_S = 3'd2; bus.AWBURST_S = 2'b01; bus.AWVALID_S = 1'b1;
    ar_set(8'h44, 32'h20, 4'd0, 2'b01);
    @(negedge clk);
    check("t3_awready", 64'(bus.AWREADY_S), 64'(1));
    check("t3_arready", 64'(bus.ARREADY_S), 64'(0));
    @(posedge clk); #1;
    bus.AWVALID_S = 1'b0;
    wdata_v[0] = 32'hCAFE_F00D; wstrb_v[0] = 4'hF;
    w_send(0, 0);
    b_recv(bid, bresp);
    check("t3_bid", 64'(bid), 64'(8'h33));
    check("t3_bresp", 64'(bresp), 64'(2'b00));
    check("t3_arready_at_b", 64'(ar_rdy_at_b), 64'(0));
    ar_wait(n);
    check("t3_ar_after_b", 64'(n), 64'(0));
    exp_v[0] = 32'hCAFE_F00D;
    r_recv(0, 1, 8'h44, 2'b00);

    // 4-beat write with early WLAST
    aw_send(8'h66, 32'h0000_0200, 4'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'h1000 + 32'(i); wstrb_v[i] = 4'hF; end
    w_send(3, 2);
    b_recv(bid, bresp);
    check("t4_bresp", 64'(bresp), 64'(2'b10));
    check("t4_bid", 64'(bid), 64'(8'h66));
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_mem%0d", i), 64'(mem[14'(32'h80 + i)]), 64'(32'h1000 + 32'(i)));

    // Zero-strobe beat still counts but leaves memory untouched
    aw_send(8'h77, 32'h0000_0300, 4'd2, 2'b01);
    wdata_v[0] = 32'hA0; wdata_v[1] = 32'hA1; wdata_v[2] = 32'hA2;
    wstrb_v[0] = 4'hF;   wstrb_v[1] = 4'h0;   wstrb_v[2] = 4'hF;
    w_send(2, 2);
    b_recv(bid, bresp);
    check("t4b_bresp", 64'(bresp), 64'(2'b00));
    check("t4b_mem0", 64'(mem[14'hC0]), 64'(32'hA0));
    check("t4b_mem1", 64'(mem[14'hC1]), 64'(32'h5555_5555));
    check("t4b_mem2", 64'(mem[14'hC2]), 64'(32'hA2));

    // FIXED burst rewrites the same word
    aw_send(8'h12, 32'h0000_0400, 4'd1, 2'b00);
    wdata_v[0] = 32'hB0; wdata_v[1] = 32'hB1; wstrb_v[0] = 4'hF; wstrb_v[1] = 4'hF;
    w_send(1, 1);
    b_recv(bid, bresp);
    check("fixed_mem100", 64'(mem[14'h100]), 64'(32'hB1));
    check("fixed_mem101", 64'(mem[14'h101]), 64'(0));

    // Word index wraps at the top of the SRAM; upper address bits ignored
    aw_send(8'h13, 32'h0001_FFFC, 4'd1, 2'b01);
    wdata_v[0] = 32'hD0; wdata_v[1] = 32'hD1;
    w_send(1, 1);
    b_recv(bid, bresp);
    check("wrap_mem3fff", 64'(mem[14'h3FFF]), 64'(32'hD0));
    check("wrap_mem0", 64'(mem[14'h0]), 64'(32'hD1));
    check("wrap_bresp", 64'(bresp), 64'(2'b00));

    // Reset during beat 2 of an 8-beat read
    ar_send(8'h55, 32'h0000_0100, 4'd7, 2'b01);
    exp_v[0] = 32'hC0DE_0040;
    r_recv(7, 1, 8'h55, 2'b00);
    n = 0;
    @(negedge clk);
    while (!bus.RVALID_S && n < TMO) begin @(negedge clk); n++; end
    check("t5_beat2_valid", 64'(bus.RVALID_S), 64'(1));
    rst = 1'b1;
    #1;
    check("t5_rvalid", 64'(bus.RVALID_S), 64'(0));
    check("t5_rlast", 64'(bus.RLAST_S), 64'(0));
    check("t5_rdata", 64'(bus.RDATA_S), 64'(0));
    check("t5_rid", 64'(bus.RID_S), 64'(0));
    check("t5_arready", 64'(bus.ARREADY_S), 64'(0));
    check("t5_awready", 64'(bus.AWREADY_S), 64'(0));
    check("t5_sram_cs", 64'(sram_cs), 64'(0));
    check("t5_sram_web", 64'(sram_web), 64'(4'hF));
    @(posedge clk); #1;
    rst = 1'b0;
    ar_send(8'h56, 32'h0000_0104, 4'd0, 2'b01);
    exp_v[0] = 32'hC0DE_0041;
    r_recv(0, 1, 8'h56, 2'b00);

    // WRAP read, LEN 3 from 0x108
    ar_send(8'h88, 32'h0000_0108, 4'd3, 2'b10);
`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
    exp_v[0] = 32'hC0DE_0042; exp_v[1] = 32'hC0DE_0043;
    exp_v[2] = 32'hC0DE_0040; exp_v[3] = 32'hC0DE_0041;
`else
    for (int i = 0; i < 4; i++) exp_v[i] = 32'hC0DE_0042 + 32'(i);
`endif
    r_recv(3, 4, 8'h88, 2'b00);

    // WRAP with an illegal length
    ar_send(8'h89, 32'h0000_0100, 4'd2, 2'b10);
    for (int i = 0; i < 3; i++) exp_v[i] = 32'hC0DE_0040 + 32'(i);
`ifdef AXI_SRAM_SLAVE_WRAP_BURST_EN
    r_recv(2, 3, 8'h89, 2'b10);
`else
    r_recv(2, 3, 8'h89, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave end) that sits between the AXI interconnect and one synchronous single-port SRAM macro (IM or DM).
- Serves the read and write bursts issued by the CPU-side masters, including single-beat accesses and INCR cache-line bursts.
- Serialises reads and writes: only one transaction is in flight at a time.

Parameters:
- ID_BITS, 8, AXI ID width (slave-side, extended ID).
- ADDR_BITS, 32, AXI address width.
- DATA_BITS, 32, AXI data width; fixed 4-byte beats.
- LEN_BITS, 4, AxLEN width; bursts of 1..16 beats.
- MEM_ADDR_BITS, 14, SRAM word-address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  in  ID_BITS/ADDR_BITS/LEN_BITS/3/2  write address channel
- AWVALID_S  in  1 ; AWREADY_S  out  1  write address handshake
- WDATA_S  in  DATA_BITS ; WSTRB_S  in  4 ; WLAST_S  in  1 ; WVALID_S  in  1 ; WREADY_S  out  1  write data channel
- BID_S  out  ID_BITS ; BRESP_S  out  2 ; BVALID_S  out  1 ; BREADY_S  in  1  write response channel
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  in  ID_BITS/ADDR_BITS/LEN_BITS/3/2  read address channel
- ARVALID_S  in  1 ; ARREADY_S  out  1  read address handshake
- RID_S  out  ID_BITS ; RDATA_S  out  DATA_BITS ; RRESP_S  out  2 ; RLAST_S  out  1 ; RVALID_S  out  1 ; RREADY_S  in  1  read data channel
- sram_cs  out  1 ; sram_oe  out  1 ; sram_web  out  4 (active-low byte write enables) ; sram_a  out  MEM_ADDR_BITS ; sram_di  out  32 ; sram_do  in  32  SRAM port; read data is valid one cycle after sram_a is applied with cs and oe high.

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE.
  - Every AXI output is 0; BRESP_S and RRESP_S are 2'b00.
  - sram_cs = 0, sram_oe = 0, sram_web = 4'hF, sram_a = 0, sram_di = 0.
  - Reset asserted mid-burst aborts the burst; no response is issued for it.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - AWREADY_S = ARREADY_S = 1 whenever the FSM is in IDLE and no handshake completed this cycle.
  - If AWVALID_S and ARVALID_S are both high, the write wins; ARREADY_S is driven low that cycle.
  - On handshake, capture ID, address, LEN and BURST; clear the beat counter.
  - Write handshake goes to WR_DATA; read handshake goes to RD_ADDR.
- RD_ADDR: sram_cs = 1, sram_oe = 1, sram_a = addr[MEM_ADDR_BITS+1:2]; next state is RD_DATA.
- RD_DATA:
  - First cycle in the state: latch sram_do into the RDATA register.
  - RVALID_S = 1; RID_S = captured ID; RRESP_S = OKAY (2'b00); RLAST_S = (beat counter == LEN).
  - RDATA_S is held stable while RREADY_S = 0.
  - On RREADY_S: if RLAST_S, go to IDLE; otherwise advance the address, increment the counter and go to RD_ADDR.
  - Throughput: 2 cycles per beat, minimum read latency 2 cycles from the AR handshake to RVALID_S.
- WR_DATA:
  - WREADY_S = 1.
  - On WVALID_S: sram_cs = 1, sram_web = ~WSTRB_S, sram_di = WDATA_S, sram_a from the current address (write in the same cycle), then advance the address and counter.
  - Burst ends on the beat where counter == LEN; go to WR_RESP.
  - An error flag is set if WLAST_S does not coincide with that final beat (early or missing WLAST).
  - WSTRB_S = 0 performs no SRAM write but still counts as a beat.
- WR_RESP:
  - BVALID_S = 1; BID_S = captured ID; BRESP_S = SLVERR (2'b10) if the error flag is set, otherwise OKAY.
  - Hold until BREADY_S, then go to IDLE.
  - A new AW can be accepted in the cycle after the B handshake, not the same cycle.
- Address advance:
  - FIXED (2'b00): the address is unchanged.
  - INCR (2'b01): +4.
  - WRAP (2'b10): behaviour per the optional feature.
  - 2'b11: treated as INCR.
- Word index wrap-around: word index wraps modulo 2^MEM_ADDR_BITS. Address bits above MEM_ADDR_BITS+1 are ignored, because decoding is done in the interconnect.
- AxSIZE_S is ignored; all beats are 4 bytes and byte selection is by WSTRB_S only.
- Outside the states listed above, sram_cs = 0, sram_oe = 0 and sram_web = 4'hF.

Optional Feature:
- Macro: AXI_SRAM_SLAVE_WRAP_BURST_EN.
- Defined: WRAP bursts are supported. The wrap boundary is (LEN+1)*4 bytes; the address increments by 4 and wraps to the aligned boundary base. LEN must be 1, 3, 7 or 15; any other LEN makes the burst complete normally but forces RRESP_S/BRESP_S = SLVERR on every beat/response.
- Undefined: WRAP is treated exactly as INCR, with no error.

Test Plan:
- Single write AW addr 0x0000_0010, LEN 0, WSTRB 4'b0011, WDATA 0xAABB_CCDD over an SRAM word of 0x1122_3344 -> sram_a = 4, word becomes 0x1122_CCDD, BRESP 2'b00, BID equals AWID.
- 4-beat INCR read from 0x100 with RREADY low for 3 cycles on beat 2 -> RDATA held stable, words 0x40..0x43 returned in order, RLAST only on beat 4.
- AWVALID and ARVALID asserted in the same cycle -> write completes first (AWREADY=1, ARREADY=0), then the read is accepted after the B handshake.
- 4-beat write with WLAST on beat 3 -> all 4 beats written, BRESP = 2'b10.
- Reset pulsed during beat 2 of an 8-beat read -> all outputs return to reset values immediately; the next AR is accepted normally.
- With AXI_SRAM_SLAVE_WRAP_BURST_EN defined: WRAP LEN 3 read at 0x108 -> word addresses 0x42, 0x43, 0x40, 0x41; without it -> 0x42, 0x43, 0x44, 0x45.
